// File: rtl/lighting_zone_ctrl.sv
// Multi-zone lighting controller: per-zone button/presence synchronizers, press and
// idle timers, and a four-state automatic/manual FSM with a global force-off.
module lighting_zone_ctrl #(
  parameter int N_ZONES     = 4,
  parameter int SHORT_CYC   = 300,
  parameter int LONG_CYC    = 5000,
  parameter int TIMEOUT_CYC = 30000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_ZONES-1:0]           btn,
  input  logic [N_ZONES-1:0]           infra,
  input  logic                         force_off,
  output logic [N_ZONES-1:0]           lamp,
  output logic [N_ZONES-1:0]           led_manual,
  output logic [N_ZONES-1:0]           timer_active,
  output logic [$clog2(N_ZONES+1)-1:0] lamps_on
);

  localparam int PW = $clog2(LONG_CYC + 1);
  localparam int IW = $clog2(TIMEOUT_CYC);
  localparam int LW = $clog2(N_ZONES + 1);

  localparam logic [PW-1:0] C_LONG    = PW'(LONG_CYC);
  localparam logic [PW-1:0] C_LONG_M1 = PW'(LONG_CYC - 1);
  localparam logic [PW-1:0] C_SHORT   = PW'(SHORT_CYC);
  localparam logic [IW-1:0] C_TMO_M1  = IW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    DESL_AUTO = 2'b00,
    LIG_AUTO  = 2'b01,
    DESL_MAN  = 2'b10,
    LIG_MAN   = 2'b11
  } state_t;

  logic [N_ZONES-1:0] r_btn_m, r_btn_s, r_btn_prev;
  logic [N_ZONES-1:0] r_inf_m, r_inf_s;
  logic [PW-1:0]      r_press [N_ZONES];
  logic [IW-1:0]      r_idle  [N_ZONES];
  state_t             r_state [N_ZONES];
  state_t             w_next  [N_ZONES];
  logic [N_ZONES-1:0] w_long, w_short, w_tmo;
  logic [LW-1:0]      w_lamps_on;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_m <= '0;
      r_btn_s <= '0;
      r_inf_m <= '0;
      r_inf_s <= '0;
    end else begin
      r_btn_m <= btn;
      r_btn_s <= r_btn_m;
      r_inf_m <= infra;
      r_inf_s <= r_inf_m;
    end
  end

  // The press counter saturates at LONG_CYC, so the long event cannot recur while held.
  always_comb begin
    w_long  = '0;
    w_short = '0;
    w_tmo   = '0;
    for (int z = 0; z < N_ZONES; z++) begin
      w_long[z]  = r_btn_s[z] && (r_press[z] == C_LONG_M1);
      w_short[z] = !r_btn_s[z] && r_btn_prev[z] &&
                   (r_press[z] > C_SHORT) && (r_press[z] < C_LONG);
      w_tmo[z]   = (r_state[z] == LIG_AUTO) && !r_inf_s[z] && (r_idle[z] == C_TMO_M1);
    end
  end

  always_comb begin
    for (int z = 0; z < N_ZONES; z++) begin
      w_next[z] = r_state[z];
      if (force_off) begin
        w_next[z] = DESL_AUTO;
      end else begin
        case (r_state[z])
          DESL_AUTO: if (w_long[z]) w_next[z] = DESL_MAN;
                     else if (r_inf_s[z]) w_next[z] = LIG_AUTO;
          LIG_AUTO:  if (w_long[z]) w_next[z] = DESL_MAN;
                     else if (w_tmo[z]) w_next[z] = DESL_AUTO;
          LIG_MAN:   if (w_long[z]) w_next[z] = LIG_AUTO;
                     else if (w_short[z]) w_next[z] = DESL_MAN;
          DESL_MAN:  if (w_long[z]) w_next[z] = LIG_AUTO;
                     else if (w_short[z]) w_next[z] = LIG_MAN;
          default:   w_next[z] = DESL_AUTO;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_prev <= '0;
      for (int z = 0; z < N_ZONES; z++) begin
        r_state[z] <= DESL_AUTO;
        r_press[z] <= '0;
        r_idle[z]  <= '0;
      end
    end else begin
      r_btn_prev <= r_btn_s;
      for (int z = 0; z < N_ZONES; z++) begin
        r_state[z] <= w_next[z];
        if (force_off || !r_btn_s[z])
          r_press[z] <= '0;
        else if (r_press[z] != C_LONG)
          r_press[z] <= r_press[z] + 1'b1;
        if (force_off || (r_state[z] != LIG_AUTO) || r_inf_s[z])
          r_idle[z] <= '0;
        else
          r_idle[z] <= r_idle[z] + 1'b1;
      end
    end
  end

  always_comb begin
    lamp         = '0;
    led_manual   = '0;
    timer_active = '0;
    for (int z = 0; z < N_ZONES; z++) begin
      lamp[z]         = (r_state[z] == LIG_AUTO) || (r_state[z] == LIG_MAN);
      led_manual[z]   = (r_state[z] == LIG_MAN)  || (r_state[z] == DESL_MAN);
      timer_active[z] = (r_state[z] == LIG_AUTO);
    end
  end

  always_comb begin
    w_lamps_on = '0;
    for (int z = 0; z < N_ZONES; z++)
      w_lamps_on = w_lamps_on + LW'(lamp[z]);
  end

  assign lamps_on = w_lamps_on;

endmodule
